// File: rtl/router_pkg.sv
// Shared constants for the router output-port FIFO.
package router_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PTR_WIDTH  = 5;

endpackage

// File: rtl/router_fifo_if.sv
// Per-port FIFO handshake: write side from the input register stage, read side to the port.
interface router_fifo_if;
  import router_pkg::*;

  logic                  write_enb;
  logic                  read_enb;
  logic [DATA_WIDTH:0]   data_in;
  logic                  ifd_state;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output write_enb, read_enb, data_in, ifd_state,
    input  empty, full, data_out
  );

  modport slave (
    input  write_enb, read_enb, data_in, ifd_state,
    output empty, full, data_out
  );

endinterface

// File: rtl/router_fifo.sv
// 16 x 9-bit synchronous FIFO for one router output port.
// Bit 8 of each entry holds the header marker for downstream length logic.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         soft_reset,
  router_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_empty;
  logic w_full;
  logic w_wr_accept;
  logic w_rd_accept;
  logic w_clear;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_accept = bus.write_enb && !w_full;
  assign w_rd_accept = bus.read_enb  && !w_empty;
  assign w_clear     = resetn || soft_reset;

  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_mem      <= '{default: '0};
    end else begin
      if (w_wr_accept) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {bus.ifd_state, bus.data_in[DATA_WIDTH-1:0]};
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_data_out <= r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH-1:0];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

  logic clock;
  logic resetn;
  logic soft_reset;

  int checks;
  int errors;

  router_fifo_if bus ();

  router_fifo #(.DEPTH(16), .DATA_WIDTH(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given requests; outputs sampled 1 time unit after the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] d,
                      input logic ifd, input logic rst, input logic srst);
    @(negedge clock);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.data_in   = {~ifd, d};
    bus.ifd_state = ifd;
    resetn        = rst;
    soft_reset    = srst;
    @(posedge clock);
    #1;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    resetn        = 1'b0;
    soft_reset    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, 1'b0, d, d[0], 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check(tag, bus.data_out, exp);
  endtask

  task automatic flags(input string tag, input logic e, input logic f);
    check({tag, "_empty"}, {7'd0, bus.empty}, {7'd0, e});
    check({tag, "_full"},  {7'd0, bus.full},  {7'd0, f});
  endtask

  logic [7:0] t2 [8];
  logic [7:0] v;

  initial begin
    checks = 0;
    errors = 0;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.data_in   = '0;
    bus.ifd_state = 1'b0;
    resetn        = 1'b0;
    soft_reset    = 1'b0;
    t2 = '{8'h3C, 8'hA5, 8'h01, 8'hFF, 8'h7E, 8'h42, 8'h99, 8'hD0};

    // 1. reset, with a write requested in the same cycle (reset wins)
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
    flags("reset", 1'b1, 1'b0);
    check("reset_dout", bus.data_out, 8'h00);
    rd("reset_read_ignored", 8'h00);

    // 2. ordering
    for (int i = 0; i < 8; i++) begin
      wr(t2[i]);
      flags("ord_wr", 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) rd("ord_rd", t2[i]);
    flags("ord_done", 1'b1, 1'b0);
    rd("ord_rd_empty_hold", 8'hD0);

    // 3. full and dropped write
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 11 + 32);
      wr(v);
      if (i == 14) flags("full_15", 1'b0, 1'b0);
    end
    flags("full_16", 1'b0, 1'b1);
    wr(8'h5A);
    flags("full_drop", 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 11 + 32);
      rd("full_rd", v);
    end
    flags("full_drained", 1'b1, 1'b0);

    // 4. soft flush of a full FIFO
    for (int i = 0; i < 16; i++) wr(8'(i + 8'hC0));
    flags("flush_pre", 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    flags("flush", 1'b1, 1'b0);
    check("flush_dout", bus.data_out, 8'h00);
    rd("flush_read_ignored", 8'h00);
    flags("flush_after_rd", 1'b1, 1'b0);

    // 5. simultaneous write+read
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    step(1'b1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
    check("sim4_dout", bus.data_out, 8'hA1);
    flags("sim4", 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    check("sim4b_dout", bus.data_out, 8'hA2);
    rd("sim_rd", 8'hA3);
    rd("sim_rd", 8'hA4);
    rd("sim_rd", 8'hB1);
    rd("sim_rd", 8'hB2);
    flags("sim_drained", 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    check("sim_empty_dout", bus.data_out, 8'hB2);
    flags("sim_empty", 1'b0, 1'b0);
    rd("sim_empty_rd", 8'hC1);
    flags("sim_empty_done", 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) wr(8'(i + 8'hD0));
    flags("sim_full_pre", 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("sim_full_dout", bus.data_out, 8'hD0);
    flags("sim_full", 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) rd("sim_full_rd", 8'(i + 8'hD0));
    flags("sim_full_done", 1'b1, 1'b0);

    // 6. wrap: one entry in flight across 40 paired write+read cycles
    wr(8'h01);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
      check("wrap_dout", bus.data_out, 8'(i));
      flags("wrap", 1'b0, 1'b0);
    end
    rd("wrap_last", 8'd41);
    flags("wrap_done", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
